// File: rtl/mux_n1_scan_pkg.sv
// Shared constants and helpers for the registered N:1 scan multiplexer.
// Imported by the top level and by the dwell counter.
package mux_n1_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Returns the smallest width w with 2**w >= value, but never less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_n1_scan_dwell_counter.sv
// Dwell counter for scan mode: counts enabled cycles on the current channel.
// tick_o marks the last cycle of a dwell, combinationally qualified by en_i.
module dwell_counter
    import mux_n1_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int              CNT_W    = clog2_min1(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);
    assign tick_o  = at_last && en_i;

    // With en_i low the count simply holds, so a paused dwell resumes exactly where it left off.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (clr_i || at_last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_n1_scan.sv
// Registered N:1 multiplexer with manual select and a timed scan through all channels.
// All outputs are registered; din_i is sampled on every enabled edge.
module mux_n1_scan
    import mux_n1_scan_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 mode_i,
    input  logic [SEL_W-1:0]     sel_i,
    input  logic [N*WIDTH-1:0]   din_i,
    output logic [WIDTH-1:0]     dout_o,
    output logic [SEL_W-1:0]     ch_idx_o,
    output logic                 ch_valid_o,
    output logic                 sel_err_o,
    output logic                 scan_tick_o
);

    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N - 1);

    logic               scan_mode;
    logic               dwell_tick;

    logic [SEL_W-1:0]   ptr_q,       ptr_d;
    logic [WIDTH-1:0]   dout_q,      dout_d;
    logic [SEL_W-1:0]   ch_idx_q,    ch_idx_d;
    logic               ch_valid_q,  ch_valid_d;
    logic               sel_err_q,   sel_err_d;
    logic               scan_tick_q, scan_tick_d;

    logic [SEL_W-1:0]   pick_idx;
    logic [WIDTH-1:0]   pick_data;
    logic               pick_hit;

    assign scan_mode = (mode_i == MODE_SCAN);

    // Manual mode holds the counter cleared so the next scan starts with a full dwell.
    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en_i),
        .clr_i   (!scan_mode),
        .tick_o  (dwell_tick)
    );

    assign pick_idx = scan_mode ? ptr_q : sel_i;

    // Explicit compare loop: an out-of-range select misses every channel and yields zero.
    always_comb begin
        pick_data = '0;
        pick_hit  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == SEL_W'(i)) begin
                pick_data = din_i[i*WIDTH +: WIDTH];
                pick_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        dout_d      = dout_q;
        ch_idx_d    = ch_idx_q;
        ch_valid_d  = ch_valid_q;
        sel_err_d   = sel_err_q;
        scan_tick_d = 1'b0;
        if (en_i) begin
            dout_d     = pick_data;
            ch_idx_d   = pick_idx;
            ch_valid_d = pick_hit;
            sel_err_d  = !pick_hit;
            if (scan_mode) begin
                scan_tick_d = dwell_tick;
                if (dwell_tick) begin
                    ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + SEL_W'(1);
                end
            end else begin
                ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q       <= '0;
            dout_q      <= '0;
            ch_idx_q    <= '0;
            ch_valid_q  <= 1'b0;
            sel_err_q   <= 1'b0;
            scan_tick_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            dout_q      <= dout_d;
            ch_idx_q    <= ch_idx_d;
            ch_valid_q  <= ch_valid_d;
            sel_err_q   <= sel_err_d;
            scan_tick_q <= scan_tick_d;
        end
    end

    assign dout_o      = dout_q;
    assign ch_idx_o    = ch_idx_q;
    assign ch_valid_o  = ch_valid_q;
    assign sel_err_o   = sel_err_q;
    assign scan_tick_o = scan_tick_q;

endmodule

// File: tb/tb_mux_n1_scan.sv
// Bench for mux_n1_scan: two instances (N=4/DWELL=4 and N=3/DWELL=1) against a
// reference model that tracks scan position as elapsed enabled scan cycles.
module tb_mux_n1_scan;

    typedef struct {
        logic [3:0] dout;
        logic [1:0] idx;
        logic       valid;
        logic       err;
        logic       tick;
        int         elapsed;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic        a_en, a_mode;
    logic [1:0]  a_sel;
    logic [15:0] a_din;
    logic [3:0]  a_dout;
    logic [1:0]  a_idx;
    logic        a_valid, a_err, a_tick;

    logic        c_en, c_mode;
    logic [1:0]  c_sel;
    logic [11:0] c_din;
    logic [3:0]  c_dout;
    logic [1:0]  c_idx;
    logic        c_valid, c_err, c_tick;

    exp_t ea, ec;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mux_n1_scan #(.WIDTH(4), .N(4), .SEL_W(2), .DWELL(4)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(a_en), .mode_i(a_mode), .sel_i(a_sel),
        .din_i(a_din), .dout_o(a_dout), .ch_idx_o(a_idx), .ch_valid_o(a_valid),
        .sel_err_o(a_err), .scan_tick_o(a_tick)
    );

    mux_n1_scan #(.WIDTH(4), .N(3), .SEL_W(2), .DWELL(1)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(c_en), .mode_i(c_mode), .sel_i(c_sel),
        .din_i(c_din), .dout_o(c_dout), .ch_idx_o(c_idx), .ch_valid_o(c_valid),
        .sel_err_o(c_err), .scan_tick_o(c_tick)
    );

    // Scan position is (elapsed / dwell) mod n; the tick lands on the last cycle of each dwell.
    function automatic exp_t model_next(exp_t s, int n, int dwell, logic en, logic mode,
                                        logic [1:0] sel, logic [15:0] din);
        exp_t r;
        int   ch;
        r = s;
        if (!en) begin
            r.tick = 1'b0;
            return r;
        end
        if (mode == 1'b0) begin
            r.elapsed = 0;
            r.idx     = sel;
            r.tick    = 1'b0;
            if (int'(sel) < n) begin
                r.dout  = din[int'(sel)*4 +: 4];
                r.valid = 1'b1;
                r.err   = 1'b0;
            end else begin
                r.dout  = 4'h0;
                r.valid = 1'b0;
                r.err   = 1'b1;
            end
        end else begin
            ch        = (s.elapsed / dwell) % n;
            r.dout    = din[ch*4 +: 4];
            r.idx     = 2'(ch);
            r.valid   = 1'b1;
            r.err     = 1'b0;
            r.tick    = ((s.elapsed % dwell) == dwell - 1);
            r.elapsed = s.elapsed + 1;
        end
        return r;
    endfunction

    task automatic clear_model();
        ea = '{dout: 4'h0, idx: 2'd0, valid: 1'b0, err: 1'b0, tick: 1'b0, elapsed: 0};
        ec = '{dout: 4'h0, idx: 2'd0, valid: 1'b0, err: 1'b0, tick: 1'b0, elapsed: 0};
    endtask

    // Advance one clock: predict from the inputs in place, then sample 1 time unit after the edge.
    task automatic cycle();
        exp_t na, nc;
        na = rst_n ? model_next(ea, 4, 4, a_en, a_mode, a_sel, a_din) : ea;
        nc = rst_n ? model_next(ec, 3, 1, c_en, c_mode, c_sel, {4'h0, c_din}) : ec;
        @(posedge clk);
        ea = na;
        ec = nc;
        #1;
    endtask

    task automatic test_reset();
        a_en = 1'b1; a_mode = 1'b1; a_din = 16'hDCBA;
        c_en = 1'b1; c_mode = 1'b1; c_din = 12'($urandom);
        for (int k = 0; k < 6; k++) begin
            cycle();
            checks++;
            if ({a_dout, a_idx, a_valid, a_err, a_tick} !== {ea.dout, ea.idx, ea.valid, ea.err, ea.tick}) begin
                errors++;
                $display("FAIL reset_prerun k=%0d got %h want %h", k,
                         {a_dout, a_idx, a_valid, a_err, a_tick}, {ea.dout, ea.idx, ea.valid, ea.err, ea.tick});
            end
        end
        #3 rst_n = 1'b0;
        clear_model();
        #1;
        checks++;
        if ({a_dout, a_idx, a_valid, a_err, a_tick} !== 9'h0) begin
            errors++;
            $display("FAIL reset_async_a got %h want 0", {a_dout, a_idx, a_valid, a_err, a_tick});
        end
        checks++;
        if ({c_dout, c_idx, c_valid, c_err, c_tick} !== 9'h0) begin
            errors++;
            $display("FAIL reset_async_c got %h want 0", {c_dout, c_idx, c_valid, c_err, c_tick});
        end
        cycle();
        #3 rst_n = 1'b1;
        cycle();
        checks++;
        if (a_dout !== 4'hA || a_idx !== 2'd0 || a_valid !== 1'b1 || a_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_restart dout=%h idx=%0d valid=%b tick=%b want A 0 1 0", a_dout, a_idx, a_valid, a_tick);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (a_idx !== 2'd0 || a_tick !== (k == 2)) begin
                errors++;
                $display("FAIL reset_full_dwell k=%0d idx=%0d tick=%b", k, a_idx, a_tick);
            end
        end
    endtask

    task automatic test_manual();
        a_mode = 1'b0; a_en = 1'b1; a_din = 16'hDCBA; a_sel = 2'd2;
        cycle();
        checks++;
        if (a_dout !== 4'hC || a_idx !== 2'd2 || a_valid !== 1'b1 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL manual_sel2 dout=%h idx=%0d valid=%b err=%b want C 2 1 0", a_dout, a_idx, a_valid, a_err);
        end
        a_din[11:8] = 4'h7;
        cycle();
        checks++;
        if (a_dout !== 4'h7) begin
            errors++;
            $display("FAIL manual_live_data dout=%h want 7", a_dout);
        end
        for (int k = 0; k < 24; k++) begin
            a_sel = 2'($urandom_range(0, 3));
            a_din = 16'($urandom);
            cycle();
            checks++;
            if ({a_dout, a_idx, a_valid, a_err, a_tick} !== {ea.dout, ea.idx, ea.valid, ea.err, ea.tick}) begin
                errors++;
                $display("FAIL manual_random k=%0d got %h want %h", k,
                         {a_dout, a_idx, a_valid, a_err, a_tick}, {ea.dout, ea.idx, ea.valid, ea.err, ea.tick});
            end
        end
    endtask

    task automatic test_out_of_range();
        c_mode = 1'b0; c_en = 1'b1; c_din = 12'($urandom); c_sel = 2'd3;
        cycle();
        checks++;
        if (c_dout !== 4'h0 || c_valid !== 1'b0 || c_err !== 1'b1 || c_idx !== 2'd3) begin
            errors++;
            $display("FAIL oor_sel3 dout=%h valid=%b err=%b idx=%0d want 0 0 1 3", c_dout, c_valid, c_err, c_idx);
        end
        c_sel = 2'd1;
        cycle();
        checks++;
        if (c_err !== 1'b0 || c_valid !== 1'b1 || c_dout !== c_din[7:4]) begin
            errors++;
            $display("FAIL oor_recover err=%b valid=%b dout=%h want 0 1 %h", c_err, c_valid, c_dout, c_din[7:4]);
        end
        for (int k = 0; k < 16; k++) begin
            c_sel = 2'($urandom_range(0, 3));
            c_din = 12'($urandom);
            cycle();
            checks++;
            if ({c_dout, c_idx, c_valid, c_err, c_tick} !== {ec.dout, ec.idx, ec.valid, ec.err, ec.tick}) begin
                errors++;
                $display("FAIL oor_random k=%0d got %h want %h", k,
                         {c_dout, c_idx, c_valid, c_err, c_tick}, {ec.dout, ec.idx, ec.valid, ec.err, ec.tick});
            end
        end
    endtask

    task automatic test_scan();
        int want_ch;
        a_en = 1'b1; a_mode = 1'b0; a_sel = 2'd3;
        cycle();
        a_din = 16'hDCBA; a_mode = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            want_ch = ((k - 1) / 4) % 4;
            checks++;
            if (a_idx !== 2'(want_ch) || a_dout !== a_din[want_ch*4 +: 4] || a_tick !== ((k % 4) == 0)
                || a_valid !== 1'b1 || a_err !== 1'b0) begin
                errors++;
                $display("FAIL scan_seq cycle=%0d idx=%0d dout=%h tick=%b want idx=%0d tick=%b",
                         k, a_idx, a_dout, a_tick, want_ch, (k % 4) == 0);
            end
        end
        for (int k = 0; k < 16; k++) begin
            a_din = 16'($urandom);
            a_sel = 2'($urandom_range(0, 3));
            cycle();
            checks++;
            if ({a_dout, a_idx, a_valid, a_err, a_tick} !== {ea.dout, ea.idx, ea.valid, ea.err, ea.tick}) begin
                errors++;
                $display("FAIL scan_random k=%0d got %h want %h", k,
                         {a_dout, a_idx, a_valid, a_err, a_tick}, {ea.dout, ea.idx, ea.valid, ea.err, ea.tick});
            end
        end
    endtask

    task automatic test_enable_freeze();
        logic [3:0] frozen_dout;
        a_en = 1'b1; a_mode = 1'b0; a_sel = 2'd0;
        cycle();
        a_mode = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        frozen_dout = ea.dout;
        checks++;
        if (a_idx !== 2'd1 || a_dout !== frozen_dout) begin
            errors++;
            $display("FAIL freeze_setup idx=%0d dout=%h want 1 %h", a_idx, a_dout, frozen_dout);
        end
        a_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_din = 16'($urandom);
            cycle();
            checks++;
            if (a_dout !== frozen_dout || a_idx !== 2'd1 || a_tick !== 1'b0) begin
                errors++;
                $display("FAIL freeze_hold k=%0d dout=%h idx=%0d tick=%b want %h 1 0", k, a_dout, a_idx, a_tick, frozen_dout);
            end
        end
        a_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (a_idx !== ((k < 2) ? 2'd1 : 2'd2) || a_tick !== (k == 1) || a_dout !== ea.dout) begin
                errors++;
                $display("FAIL freeze_resume k=%0d idx=%0d tick=%b dout=%h want dout %h", k, a_idx, a_tick, a_dout, ea.dout);
            end
        end
    endtask

    task automatic test_wrap();
        c_en = 1'b1; c_mode = 1'b0; c_sel = 2'd0; c_din = 12'($urandom);
        cycle();
        c_mode = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cycle();
            checks++;
            if (c_idx !== 2'(k % 3) || c_tick !== 1'b1 || c_dout !== c_din[(k % 3)*4 +: 4]) begin
                errors++;
                $display("FAIL wrap_seq k=%0d idx=%0d tick=%b want idx=%0d tick=1", k, c_idx, c_tick, k % 3);
            end
        end
        c_mode = 1'b0; c_sel = 2'd2;
        cycle();
        checks++;
        if (c_dout !== c_din[11:8] || c_tick !== 1'b0 || c_idx !== 2'd2) begin
            errors++;
            $display("FAIL wrap_to_manual dout=%h tick=%b idx=%0d want %h 0 2", c_dout, c_tick, c_idx, c_din[11:8]);
        end
        c_mode = 1'b1;
        cycle();
        checks++;
        if (c_idx !== 2'd0 || c_dout !== c_din[3:0]) begin
            errors++;
            $display("FAIL wrap_rescan idx=%0d dout=%h want 0 %h", c_idx, c_dout, c_din[3:0]);
        end
    endtask

    task automatic test_random_mixed();
        for (int k = 0; k < 300; k++) begin
            a_en = ($urandom_range(0, 7) != 0);
            c_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) a_mode = ~a_mode;
            if ($urandom_range(0, 15) == 0) c_mode = ~c_mode;
            a_sel = 2'($urandom_range(0, 3));
            c_sel = 2'($urandom_range(0, 3));
            a_din = 16'($urandom);
            c_din = 12'($urandom);
            if ((k % 97) == 50) begin
                #2 rst_n = 1'b0;
                clear_model();
                #2 rst_n = 1'b1;
            end
            cycle();
            checks++;
            if ({a_dout, a_idx, a_valid, a_err, a_tick} !== {ea.dout, ea.idx, ea.valid, ea.err, ea.tick}) begin
                errors++;
                $display("FAIL mixed_a k=%0d got %h want %h", k,
                         {a_dout, a_idx, a_valid, a_err, a_tick}, {ea.dout, ea.idx, ea.valid, ea.err, ea.tick});
            end
            checks++;
            if ({c_dout, c_idx, c_valid, c_err, c_tick} !== {ec.dout, ec.idx, ec.valid, ec.err, ec.tick}) begin
                errors++;
                $display("FAIL mixed_c k=%0d got %h want %h", k,
                         {c_dout, c_idx, c_valid, c_err, c_tick}, {ec.dout, ec.idx, ec.valid, ec.err, ec.tick});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_en = 1'b0; a_mode = 1'b0; a_sel = 2'd0; a_din = 16'h0;
        c_en = 1'b0; c_mode = 1'b0; c_sel = 2'd0; c_din = 12'h0;
        clear_model();
        #12 rst_n = 1'b1;
        test_reset();
        test_manual();
        test_out_of_range();
        test_scan();
        test_enable_freeze();
        test_wrap();
        test_random_mixed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
